// File: rtl/reg_readout_serializer_pkg.sv
// Shared types and helpers for the register readout serializer.
// Exports state_e, nbytes() and cnt_w().
package reg_readout_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam int TIMEOUT_DEFAULT = 16;

  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction

  function automatic int cnt_w(input int t);
    return $clog2(t + 1);
  endfunction

  localparam int CNT_W = cnt_w(TIMEOUT_DEFAULT);

endpackage

// File: rtl/reg_readout_serializer_shifter.sv
// Byte shifter: loads a zero-extended word, emits one byte per advance.
// Ports: clk/rst, load+load_val, advance, byte_o, last_o.
module reg_word_shifter
  import reg_readout_serializer_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [REG_WIDTH-1:0] load_val,
  input  logic                 advance,
  output logic [7:0]           byte_o,
  output logic                 last_o
);

  localparam int NB = nbytes(REG_WIDTH);
  localparam int W  = NB * 8;
  localparam int IW = $clog2(NB + 1);

  logic [W-1:0]  word_q, word_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (load) begin
      word_d = W'(load_val);
      idx_d  = '0;
    end else if (advance) begin
      word_d = MSB_FIRST ? (word_q << 8) : (word_q >> 8);
      idx_d  = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign byte_o = MSB_FIRST ? word_q[W-1 -: 8] : word_q[7:0];
  assign last_o = (idx_q == IW'(NB - 1));

endmodule

// File: rtl/reg_readout_serializer.sv
// Register readout engine: decode, strobe, timed wait, byte serialise.
// Ports: instr req/ready, read strobe/vals/valid, byte stream, errors, busy.
module reg_readout_serializer
  import reg_readout_serializer_pkg::*;
#(
  parameter int NUM_REGS       = 4,
  parameter int REG_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int ADDR_STRIDE    = 4,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  sysClk,
  input  logic                  sysRst,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [NUM_REGS-1:0]   read_strobe,
  input  logic [REG_WIDTH-1:0]  read_vals,
  input  logic                  read_valid,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  byte_last,
  output logic                  addr_error,
  output logic                  timeout_error,
  output logic                  busy
);

  localparam int CW = cnt_w(TIMEOUT_CYCLES);
  localparam int SH = $clog2(ADDR_STRIDE);
  localparam logic [ADDR_WIDTH-1:0] MASK =
    ADDR_WIDTH'(ADDR_STRIDE - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REGS-1:0] strobe_q, strobe_d;
  logic                aerr_q, aerr_d;
  logic                terr_q, terr_d;
  logic                bv_q, bv_d;

  logic [ADDR_WIDTH-1:0] addr_idx;
  logic                  addr_ok;
  logic                  sh_load, sh_adv, sh_last;

  assign addr_idx = reg_addr >> SH;
  assign addr_ok  = ((reg_addr & MASK) == '0) &&
                    (32'(addr_idx) < 32'(NUM_REGS));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_d = '0;
    aerr_d   = 1'b0;
    terr_d   = 1'b0;
    bv_d     = bv_q;
    sh_load  = 1'b0;
    sh_adv   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          if (addr_ok) begin
            state_d  = ST_WAIT;
            strobe_d = NUM_REGS'(1) << addr_idx;
            cnt_d    = '0;
          end else begin
            aerr_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // A read on the last allowed cycle beats the timeout.
        if (read_valid) begin
          sh_load = 1'b1;
          bv_d    = 1'b1;
          state_d = ST_SEND;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SEND: begin
        if (bv_q && byte_ready) begin
          if (sh_last) begin
            bv_d    = 1'b0;
            state_d = ST_IDLE;
          end else begin
            sh_adv = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      strobe_q <= '0;
      aerr_q   <= 1'b0;
      terr_q   <= 1'b0;
      bv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      aerr_q   <= aerr_d;
      terr_q   <= terr_d;
      bv_q     <= bv_d;
    end
  end

  reg_word_shifter #(
    .REG_WIDTH (REG_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (sysClk),
    .rst      (sysRst),
    .load     (sh_load),
    .load_val (read_vals),
    .advance  (sh_adv),
    .byte_o   (byte_out),
    .last_o   (sh_last)
  );

  assign instr_ready   = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign read_strobe   = strobe_q;
  assign addr_error    = aerr_q;
  assign timeout_error = terr_q;
  assign byte_valid    = bv_q;
  // Shifter index idles on the last byte; only flag it while sending.
  assign byte_last     = sh_last & bv_q;

endmodule

// File: tb/tb_reg_readout_serializer.sv
// Directed bench for reg_readout_serializer (default and 12-bit LSB-first).
// Table of transactions plus hand sequences for reset and narrow word.
module tb_reg_readout_serializer;

  localparam int K_OK = 0;
  localparam int K_AE = 1;
  localparam int K_TO = 2;
  localparam int TO   = 16;

  typedef struct {
    logic [7:0]  addr;
    int          kind;
    logic [3:0]  strobe;
    int          rv_cycle;
    logic [31:0] vals;
    logic [7:0]  rdy_pat;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  reg_addr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  read_strobe;
  logic [31:0] read_vals = '0;
  logic        read_valid = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        byte_last;
  logic        addr_error;
  logic        timeout_error;
  logic        busy;

  logic [7:0]  b_addr = '0;
  logic        b_ivalid = 1'b0;
  logic        b_iready;
  logic [3:0]  b_strobe;
  logic [11:0] b_vals = '0;
  logic        b_rvalid = 1'b0;
  logic [7:0]  b_byte;
  logic        b_bvalid;
  logic        b_bready = 1'b0;
  logic        b_last;
  logic        b_aerr;
  logic        b_terr;
  logic        b_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_readout_serializer dut_a (
    .sysClk        (clk),
    .sysRst        (rst),
    .reg_addr      (reg_addr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .read_strobe   (read_strobe),
    .read_vals     (read_vals),
    .read_valid    (read_valid),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .byte_last     (byte_last),
    .addr_error    (addr_error),
    .timeout_error (timeout_error),
    .busy          (busy)
  );

  reg_readout_serializer #(
    .REG_WIDTH (12),
    .MSB_FIRST (1'b0)
  ) dut_b (
    .sysClk        (clk),
    .sysRst        (rst),
    .reg_addr      (b_addr),
    .instr_valid   (b_ivalid),
    .instr_ready   (b_iready),
    .read_strobe   (b_strobe),
    .read_vals     (b_vals),
    .read_valid    (b_rvalid),
    .byte_out      (b_byte),
    .byte_valid    (b_bvalid),
    .byte_ready    (b_bready),
    .byte_last     (b_last),
    .addr_error    (b_aerr),
    .timeout_error (b_terr),
    .busy          (b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int i;
    int k;
    bit got_rv;
    chk("idle_ready", 32'(instr_ready), 1);
    reg_addr    = v.addr;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    if (v.kind == K_AE) begin
      chk("aerr_pulse", 32'(addr_error), 1);
      chk("aerr_strobe", 32'(read_strobe), 0);
      chk("aerr_busy", 32'(busy), 0);
      step();
      chk("aerr_clear", 32'(addr_error), 0);
      chk("aerr_bvalid", 32'(byte_valid), 0);
      chk("aerr_ready", 32'(instr_ready), 1);
      return;
    end
    got_rv = 1'b0;
    for (int j = 1; j <= TO; j++) begin
      chk("strobe", 32'(read_strobe),
          (j == 1) ? 32'(v.strobe) : 32'd0);
      chk("no_terr", 32'(timeout_error), 0);
      if (j == v.rv_cycle) begin
        read_valid = 1'b1;
        read_vals  = v.vals;
      end
      step();
      read_valid = 1'b0;
      read_vals  = '0;
      if (j == v.rv_cycle) begin
        got_rv = 1'b1;
        break;
      end
    end
    if (v.kind == K_TO) begin
      chk("terr_pulse", 32'(timeout_error), 1);
      chk("terr_ready", 32'(instr_ready), 1);
      chk("terr_bvalid", 32'(byte_valid), 0);
      step();
      chk("terr_clear", 32'(timeout_error), 0);
      return;
    end
    chk("rv_seen", 32'(got_rv), 1);
    i = 0;
    k = 0;
    while (i < 4 && k < 64) begin
      chk("bvalid", 32'(byte_valid), 1);
      chk("byte", 32'(byte_out), 32'(v.exp[31-8*i -: 8]));
      chk("blast", 32'(byte_last), (i == 3) ? 32'd1 : 32'd0);
      chk("busy_send", 32'(instr_ready), 0);
      byte_ready = v.rdy_pat[k % 8];
      step();
      if (byte_ready) i++;
      k++;
    end
    byte_ready = 1'b0;
    chk("bytes_done", 32'(i), 4);
    chk("end_bvalid", 32'(byte_valid), 0);
    chk("end_ready", 32'(instr_ready), 1);
    chk("end_blast", 32'(byte_last), 0);
    chk("end_terr", 32'(timeout_error), 0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h04, K_OK, 4'b0010, 3,  32'hDEADBEEF,
                8'hFF, 32'hDEADBEEF};
    vecs[1] = '{8'h00, K_OK, 4'b0001, 1,  32'h12345678,
                8'b1001_1001, 32'h12345678};
    vecs[2] = '{8'h05, K_AE, 4'b0000, 0,  32'h0,
                8'h00, 32'h0};
    vecs[3] = '{8'h10, K_AE, 4'b0000, 0,  32'h0,
                8'h00, 32'h0};
    vecs[4] = '{8'h08, K_TO, 4'b0100, 0,  32'h0,
                8'h00, 32'h0};
    vecs[5] = '{8'h08, K_OK, 4'b0100, 16, 32'h01020304,
                8'hFF, 32'h01020304};
    vecs[6] = '{8'h0C, K_OK, 4'b1000, 2,  32'h000000A5,
                8'hAA, 32'h000000A5};

    rst = 1'b1;
    step();
    step();
    chk("rst_strobe", 32'(read_strobe), 0);
    chk("rst_bvalid", 32'(byte_valid), 0);
    chk("rst_byte", 32'(byte_out), 0);
    chk("rst_blast", 32'(byte_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_errs", {30'd0, addr_error, timeout_error}, 0);
    rst = 1'b0;
    step();
    chk("rst_ready", 32'(instr_ready), 1);

    for (int n = 0; n < 7; n++) begin
      run_txn(vecs[n]);
      step();
    end

    // Reset in the middle of a word.
    reg_addr    = 8'h04;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("mr_strobe", 32'(read_strobe), 32'h2);
    read_valid = 1'b1;
    read_vals  = 32'hCAFEF00D;
    step();
    read_valid = 1'b0;
    byte_ready = 1'b1;
    chk("mr_b0", 32'(byte_out), 32'hCA);
    step();
    chk("mr_b1", 32'(byte_out), 32'hFE);
    step();
    chk("mr_b2", 32'(byte_out), 32'hF0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    byte_ready = 1'b0;
    chk("mr_bvalid", 32'(byte_valid), 0);
    chk("mr_byte", 32'(byte_out), 0);
    chk("mr_blast", 32'(byte_last), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_strobe0", 32'(read_strobe), 0);
    chk("mr_ready", 32'(instr_ready), 1);
    run_txn(vecs[1]);

    // 12-bit word, LSB first.
    chk("b_ready0", 32'(b_iready), 1);
    b_addr   = 8'h0C;
    b_ivalid = 1'b1;
    step();
    b_ivalid = 1'b0;
    chk("b_strobe", 32'(b_strobe), 32'h8);
    b_rvalid = 1'b1;
    b_vals   = 12'hABC;
    step();
    b_rvalid = 1'b0;
    chk("b_bv0", 32'(b_bvalid), 1);
    chk("b_byte0", 32'(b_byte), 32'hBC);
    chk("b_last0", 32'(b_last), 0);
    b_bready = 1'b1;
    step();
    chk("b_bv1", 32'(b_bvalid), 1);
    chk("b_byte1", 32'(b_byte), 32'h0A);
    chk("b_last1", 32'(b_last), 1);
    step();
    b_bready = 1'b0;
    chk("b_done_bv", 32'(b_bvalid), 0);
    chk("b_done_rdy", 32'(b_iready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_readout_serializer.md
Name: reg_readout_serializer

Overview:
Parametrised register-readout engine between the instruction data buffer and the SPI byte buffer. It accepts a register read request by address and decodes it to a one-hot read strobe across NUM_REGS read registers. It waits, with a timeout, for the addressed register's value, then serialises the REG_WIDTH-bit value into bytes using a valid/ready handshake. Invalid addresses and timeouts are reported as error pulses instead of bytes.

Parameters:
NUM_REGS, 4, number of readable registers (index 0 = status, 1 = error, ...)
REG_WIDTH, 32, width of each register value; 1..64
ADDR_WIDTH, 8, width of reg_addr
ADDR_STRIDE, 4, address spacing between registers; power of 2; register i sits at i*ADDR_STRIDE
MSB_FIRST, 1, 1 = most-significant byte sent first; 0 = least-significant first
TIMEOUT_CYCLES, 16, maximum WAIT cycles allowed for read_valid; >= 1

Ports:
sysClk  in  1  system clock; all logic on its rising edge
sysRst  in  1  synchronous, active-high reset
reg_addr  in  ADDR_WIDTH  register address of the request
instr_valid  in  1  request present
instr_ready  out  1  block idle and able to accept a request
read_strobe  out  NUM_REGS  one-hot read request to the register bank; one-cycle pulse
read_vals  in  REG_WIDTH  value returned by the register bank
read_valid  in  1  read_vals valid this cycle
byte_out  out  8  serialised byte
byte_valid  out  1  byte_out valid
byte_ready  in  1  downstream accepts byte_out
byte_last  out  1  byte_out is the final byte of the word
addr_error  out  1  one-cycle pulse: invalid address rejected
timeout_error  out  1  one-cycle pulse: read_valid never arrived
busy  out  1  state != IDLE

Behaviour:
- Reset (sysRst high at an edge): state=IDLE. read_strobe, byte_out, byte_valid, byte_last, addr_error, timeout_error, busy and the timeout counter all go to 0. Reset mid-operation abandons the word silently.
- NUM_BYTES = ceil(REG_WIDTH/8). The value is zero-extended to NUM_BYTES*8 bits before serialising.
- Address decode: valid iff reg_addr % ADDR_STRIDE == 0 and reg_addr/ADDR_STRIDE < NUM_REGS.
- instr_ready = (state==IDLE), combinational from state. A request is accepted when instr_valid && instr_ready.
- State machine: IDLE, WAIT, SEND.
- IDLE, accept with valid address at edge N: state goes to WAIT. read_strobe = onehot(index) during cycle N+1 only. The timeout counter is cleared.
- IDLE, accept with invalid address: addr_error is high for cycle N+1 and state stays IDLE. No strobe and no bytes.
- IDLE: read_valid is ignored.
- WAIT: read_valid is sampled every cycle, including the strobe cycle.
  - On read_valid, read_vals is captured into the shift register and state goes to SEND. byte_valid rises the next cycle with the first byte.
  - Otherwise the counter increments.
  - After TIMEOUT_CYCLES WAIT cycles without read_valid: timeout_error pulses for one cycle and state returns to IDLE.
  - If read_valid arrives on the final allowed cycle, the read wins.
- SEND: byte_valid=1. byte_out and byte_last must stay stable while byte_valid && !byte_ready.
  - Each byte_valid && byte_ready advances to the next byte.
  - Throughput is one byte per cycle when byte_ready is held high.
  - byte_last=1 only with the final byte.
  - When the final byte is accepted: byte_valid=0 and state=IDLE on the next cycle, so instr_ready is high that cycle.
- Byte order: with MSB_FIRST=1 the sequence is byte NUM_BYTES-1 down to byte 0; with MSB_FIRST=0 it is byte 0 up.
- instr_valid while busy is not accepted. The request must be held by the upstream until instr_ready.
- Worst-case latency from accept to first byte: TIMEOUT_CYCLES+1 cycles.

Decomposition:
- Shared package: state encoding (IDLE/WAIT/SEND); a function nbytes(width) = (width+7)/8; localparam for the counter width = clog2(TIMEOUT_CYCLES+1).
- Sub-module reg_word_shifter:
  - loads the zero-extended word and shifts out one byte per advance, honouring MSB_FIRST;
  - outputs the current byte and a last flag.
- The FSM, address decode and timeout stay in the top module.

Test Plan:
1. Defaults, reg_addr=0x04, read_valid with read_vals=0xDEADBEEF two cycles after the strobe, byte_ready=1 -> read_strobe=4'b0010 for one cycle; bytes DE,AD,BE,EF on consecutive cycles; byte_last only on EF; instr_ready=1 the cycle after EF.
2. reg_addr=0x00, read_vals=0x12345678, byte_ready toggling 1,0,0,1,... -> byte_out holds steady while ready=0; sequence 12,34,56,78 with no duplicates or drops.
3. reg_addr=0x05, then 0x10 -> addr_error single-cycle pulse each time; read_strobe stays 0; byte_valid stays 0; instr_ready returns high.
4. reg_addr=0x08, read_valid never asserted -> timeout_error pulses once exactly TIMEOUT_CYCLES=16 cycles after the strobe cycle starts WAIT; state returns to IDLE. Repeat with read_valid on cycle 16 -> bytes are sent and there is no timeout.
5. Request 0x04 with 0xCAFEF00D; assert sysRst after 2 bytes accepted -> all outputs 0 the next cycle; a new request 0x00 completes normally.
6. REG_WIDTH=12, MSB_FIRST=0, read_vals=0xABC -> two bytes BC then 0A; byte_last on 0A.
